// File: rtl/prirv32_fetch_stage.sv
// prirv32_fetch_stage: instruction fetch front-end.
//
// Owns the PC and issues word-aligned fetches over a valid/ready request channel, with up to
// MAX_OUTSTANDING requests in flight. In-order responses are tagged with their PC, buffered in a
// FQ_DEPTH-entry fetch queue and handed to decode over a valid/ready handshake. A redirect flushes
// the queue, restarts fetch at the new PC and drops every response still owed for older requests.
//
// Ports:
//   clk_i, rst_n                      clock; synchronous active-low reset
//   imem_req_valid_o/ready_i/addr_o   instruction-memory request channel
//   imem_rsp_valid_i/data_i/err_i     in-order response channel, always accepted
//   redirect_i, redirect_pc_i         flush and restart fetch at redirect_pc_i (bits [1:0] ignored)
//   inst_valid_o/ready_i              decode handshake for the queue head
//   inst_data_o/pc_o/err_o            head instruction, its PC and access-fault flag
//   fq_count_o                        current queue occupancy
//
// Build option: define FETCH_BYPASS_EN to let a response reach decode in the cycle it arrives when
// the queue is empty; if decode also takes it, the entry is never written into the queue.

module prirv32_fetch_stage #(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     FQ_DEPTH        = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_n,
    output logic                          imem_req_valid_o,
    input  logic                          imem_req_ready_i,
    output logic [XLEN-1:0]               imem_req_addr_o,
    input  logic                          imem_rsp_valid_i,
    input  logic [31:0]                   imem_rsp_data_i,
    input  logic                          imem_rsp_err_i,
    input  logic                          redirect_i,
    input  logic [XLEN-1:0]               redirect_pc_i,
    output logic                          inst_valid_o,
    input  logic                          inst_ready_i,
    output logic [31:0]                   inst_data_o,
    output logic [XLEN-1:0]               inst_pc_o,
    output logic                          inst_err_o,
    output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count_o
);

    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   discard_q, discard_d;

    // PC tags of accepted requests, popped in order as responses return.
    logic [XLEN-1:0] tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0]   tag_wptr_q, tag_rptr_q;

    logic [31:0]     fq_data [FQ_DEPTH];
    logic [XLEN-1:0] fq_pc   [FQ_DEPTH];
    logic            fq_err  [FQ_DEPTH];
    logic [PW-1:0]   fq_wptr_q, fq_rptr_q;
    logic [CW-1:0]   fq_count_q, fq_count_d;

    logic            req_fire, rsp_drop, head_valid, bypass, fq_push, fq_pop;
    logic [31:0]     credit_used;
    logic [XLEN-1:0] rsp_pc;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc_i[1:0];
    assign rsp_pc              = tag_mem[tag_rptr_q];

    always_comb begin
        // Queue slots already claimed: stored entries plus responses that will actually be kept.
        credit_used      = 32'(fq_count_q) + 32'(outstanding_q) - 32'(discard_q);
        imem_req_valid_o = rst_n && (32'(outstanding_q) < MAX_OUTSTANDING)
                           && (credit_used < FQ_DEPTH);
        imem_req_addr_o  = pc_q;
        req_fire         = imem_req_valid_o && imem_req_ready_i;

        // Responses in the redirect cycle belong to the old stream as well.
        rsp_drop   = redirect_i || (discard_q != '0);
        head_valid = (fq_count_q != '0);
`ifdef FETCH_BYPASS_EN
        bypass     = !head_valid && imem_rsp_valid_i && !rsp_drop;
`else
        bypass     = 1'b0;
`endif
        inst_valid_o = head_valid || bypass;
        fq_pop       = head_valid && inst_ready_i;
        fq_push      = imem_rsp_valid_i && !rsp_drop && !(bypass && inst_ready_i);

        inst_data_o = '0;
        inst_pc_o   = '0;
        inst_err_o  = 1'b0;
        if (head_valid) begin
            inst_data_o = fq_data[fq_rptr_q];
            inst_pc_o   = fq_pc[fq_rptr_q];
            inst_err_o  = fq_err[fq_rptr_q];
        end else if (bypass) begin
            inst_data_o = imem_rsp_data_i;
            inst_pc_o   = rsp_pc;
            inst_err_o  = imem_rsp_err_i;
        end
        fq_count_o = fq_count_q;

        outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem_rsp_valid_i);

        // outstanding_d already excludes a response landing in the redirect cycle.
        discard_d = discard_q;
        if (redirect_i) begin
            discard_d = outstanding_d;
        end else if (imem_rsp_valid_i && (discard_q != '0)) begin
            discard_d = discard_q - OW'(1);
        end

        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end

        fq_count_d = redirect_i ? '0 : fq_count_q + CW'(fq_push) - CW'(fq_pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            tag_wptr_q    <= '0;
            tag_rptr_q    <= '0;
            fq_wptr_q     <= '0;
            fq_rptr_q     <= '0;
            fq_count_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fq_count_q    <= fq_count_d;
            if (req_fire) begin
                tag_wptr_q <= (tag_wptr_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wptr_q + TW'(1);
            end
            if (imem_rsp_valid_i) begin
                tag_rptr_q <= (tag_rptr_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rptr_q + TW'(1);
            end
            if (redirect_i) begin
                fq_wptr_q <= '0;
                fq_rptr_q <= '0;
            end else begin
                if (fq_push) fq_wptr_q <= fq_wptr_q + PW'(1);
                if (fq_pop)  fq_rptr_q <= fq_rptr_q + PW'(1);
            end
        end
    end

    // Storage needs no reset; occupancy and pointers decide what is visible.
    always_ff @(posedge clk_i) begin
        if (req_fire) begin
            tag_mem[tag_wptr_q] <= pc_q;
        end
        if (fq_push) begin
            fq_data[fq_wptr_q] <= imem_rsp_data_i;
            fq_pc[fq_wptr_q]   <= rsp_pc;
            fq_err[fq_wptr_q]  <= imem_rsp_err_i;
        end
    end

endmodule

// File: tb/tb_prirv32_fetch_stage.sv
module tb_prirv32_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        imem_rsp_err_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_data_o;
    logic [31:0] inst_pc_o;
    logic        inst_err_o;
    logic [2:0]  fq_count_o;

    prirv32_fetch_stage dut (
        .clk_i            (clk_i),
        .rst_n            (rst_n),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_data_o      (inst_data_o),
        .inst_pc_o        (inst_pc_o),
        .inst_err_o       (inst_err_o),
        .fq_count_o       (fq_count_o)
    );

    always #5 clk_i = ~clk_i;

    int ncheck = 0;
    int nerr   = 0;
    int cyc    = 0;
    int lat    = 1;
    logic        err_en   = 1'b0;
    logic [31:0] err_addr = '0;

    // Memory model: accepted addresses with the cycle their response is due.
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    // Logs of accepted requests and of instructions taken by decode.
    logic [31:0] req_log[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];
    logic        got_err[$];
    int          got_cyc[$];

    task automatic clear_logs();
        req_log.delete(); got_pc.delete(); got_data.delete(); got_err.delete(); got_cyc.delete();
    endtask

    task automatic tick();
        logic fire;
        logic [31:0] faddr;
        @(negedge clk_i);
        fire  = imem_req_valid_o && imem_req_ready_i;
        faddr = imem_req_addr_o;
        if (fire) req_log.push_back(faddr);
        if (inst_valid_o && inst_ready_i) begin
            got_pc.push_back(inst_pc_o);
            got_data.push_back(inst_data_o);
            got_err.push_back(inst_err_o);
            got_cyc.push_back(cyc);
        end
        @(posedge clk_i);
        #1;
        if (imem_rsp_valid_i) begin
            mq_addr.delete(0);
            mq_due.delete(0);
        end
        if (fire) begin
            mq_addr.push_back(faddr);
            mq_due.push_back(cyc + lat);
        end
        cyc++;
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mq_addr[0];
            imem_rsp_err_i   = err_en && (mq_addr[0] == err_addr);
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
            imem_rsp_err_i   = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        imem_req_ready_i = 1'b0;
        inst_ready_i     = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        imem_rsp_err_i   = 1'b0;
        err_en           = 1'b0;
        mq_addr.delete();
        mq_due.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        lat   = 1;
        clear_logs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        ncheck++; if (imem_req_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_req_valid got %h exp 0", imem_req_valid_o); end
        ncheck++; if (inst_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_inst_valid got %h exp 0", inst_valid_o); end
        ncheck++; if (inst_pc_o !== 32'h0) begin nerr++; $display("FAIL rst_inst_pc got %h exp 0", inst_pc_o); end
        ncheck++; if (inst_data_o !== 32'h0) begin nerr++; $display("FAIL rst_inst_data got %h exp 0", inst_data_o); end
        ncheck++; if (inst_err_o !== 1'b0) begin nerr++; $display("FAIL rst_inst_err got %h exp 0", inst_err_o); end
        ncheck++; if (fq_count_o !== 3'd0) begin nerr++; $display("FAIL rst_fq_count got %0d exp 0", fq_count_o); end
        rst_n = 1'b1;
        tick();
        ncheck++; if (imem_req_valid_o !== 1'b1) begin nerr++; $display("FAIL post_rst_req_valid got %h exp 1", imem_req_valid_o); end
        ncheck++; if (imem_req_addr_o !== 32'h0) begin nerr++; $display("FAIL post_rst_req_addr got %h exp 0", imem_req_addr_o); end
    endtask

    task automatic test_stream();
        do_reset();
        imem_req_ready_i = 1'b1;
        inst_ready_i     = 1'b1;
        repeat (12) tick();
        ncheck++;
        if (got_pc.size() < 8 || req_log.size() < 8) begin
            nerr++; $display("FAIL stream_len got %0d exp >=8", got_pc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                ncheck++; if (req_log[i] !== 32'(i * 4)) begin nerr++; $display("FAIL stream_req[%0d] got %h exp %h", i, req_log[i], 32'(i * 4)); end
                ncheck++; if (got_pc[i] !== 32'(i * 4)) begin nerr++; $display("FAIL stream_pc[%0d] got %h exp %h", i, got_pc[i], 32'(i * 4)); end
                ncheck++; if (got_data[i] !== 32'(i * 4)) begin nerr++; $display("FAIL stream_data[%0d] got %h exp %h", i, got_data[i], 32'(i * 4)); end
                ncheck++; if (got_cyc[i] !== got_cyc[0] + i) begin nerr++; $display("FAIL stream_gap[%0d] got %0d exp %0d", i, got_cyc[i], got_cyc[0] + i); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_req_ready_i = 1'b1;
        inst_ready_i     = 1'b0;
        repeat (20) tick();
        ncheck++; if (fq_count_o !== 3'd4) begin nerr++; $display("FAIL bp_count got %0d exp 4", fq_count_o); end
        ncheck++; if (imem_req_valid_o !== 1'b0) begin nerr++; $display("FAIL bp_req_valid got %h exp 0", imem_req_valid_o); end
        ncheck++; if (req_log.size() !== 4) begin nerr++; $display("FAIL bp_req_count got %0d exp 4", req_log.size()); end
        ncheck++; if (inst_pc_o !== 32'h0) begin nerr++; $display("FAIL bp_head_pc got %h exp 0", inst_pc_o); end
        imem_req_ready_i = 1'b0;
        inst_ready_i     = 1'b1;
        repeat (6) tick();
        ncheck++;
        if (got_pc.size() !== 4) begin
            nerr++; $display("FAIL bp_drain_len got %0d exp 4", got_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                ncheck++; if (got_pc[i] !== 32'(i * 4)) begin nerr++; $display("FAIL bp_drain_pc[%0d] got %h exp %h", i, got_pc[i], 32'(i * 4)); end
            end
        end
        ncheck++; if (fq_count_o !== 3'd0) begin nerr++; $display("FAIL bp_drain_count got %0d exp 0", fq_count_o); end
    endtask

    task automatic test_redirect();
        do_reset();
        lat              = 3;
        imem_req_ready_i = 1'b1;
        inst_ready_i     = 1'b1;
        repeat (2) tick();
        ncheck++; if (imem_req_valid_o !== 1'b0) begin nerr++; $display("FAIL redir_inflight_limit got %h exp 0", imem_req_valid_o); end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        repeat (12) tick();
        ncheck++;
        if (got_pc.size() < 2 || req_log.size() < 3) begin
            nerr++; $display("FAIL redir_len got %0d exp >=2", got_pc.size());
        end else begin
            ncheck++; if (req_log[2] !== 32'h100) begin nerr++; $display("FAIL redir_req got %h exp 100", req_log[2]); end
            ncheck++; if (got_pc[0] !== 32'h100) begin nerr++; $display("FAIL redir_first_pc got %h exp 100", got_pc[0]); end
            ncheck++; if (got_data[0] !== 32'h100) begin nerr++; $display("FAIL redir_first_data got %h exp 100", got_data[0]); end
            ncheck++; if (got_pc[1] !== 32'h104) begin nerr++; $display("FAIL redir_second_pc got %h exp 104", got_pc[1]); end
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        imem_req_ready_i = 1'b1;
        inst_ready_i     = 1'b1;
        repeat (8) tick();
        ncheck++;
        if (!(imem_req_valid_o === 1'b1 && imem_req_addr_o === 32'h20 && imem_rsp_valid_i === 1'b1)) begin
            nerr++; $display("FAIL samecyc_setup got valid %h addr %h exp valid 1 addr 20", imem_req_valid_o, imem_req_addr_o);
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h203;
        tick();
        redirect_i = 1'b0;
        repeat (10) tick();
        ncheck++;
        if (got_pc.size() < 9 || req_log.size() < 10) begin
            nerr++; $display("FAIL samecyc_len got %0d exp >=9", got_pc.size());
        end else begin
            ncheck++; if (req_log[8] !== 32'h20) begin nerr++; $display("FAIL samecyc_req20 got %h exp 20", req_log[8]); end
            ncheck++; if (req_log[9] !== 32'h200) begin nerr++; $display("FAIL samecyc_req200 got %h exp 200", req_log[9]); end
            ncheck++; if (got_pc[6] !== 32'h18) begin nerr++; $display("FAIL samecyc_last_old got %h exp 18", got_pc[6]); end
            ncheck++; if (got_pc[7] !== 32'h200) begin nerr++; $display("FAIL samecyc_target got %h exp 200", got_pc[7]); end
            ncheck++; if (got_pc[8] !== 32'h204) begin nerr++; $display("FAIL samecyc_next got %h exp 204", got_pc[8]); end
        end
        imem_req_ready_i = 1'b0;
        repeat (6) tick();
        ncheck++; if (fq_count_o !== 3'd0) begin nerr++; $display("FAIL samecyc_count got %0d exp 0", fq_count_o); end
        ncheck++; if (imem_req_valid_o !== 1'b1) begin nerr++; $display("FAIL samecyc_credit got %h exp 1", imem_req_valid_o); end
    endtask

    task automatic test_error();
        do_reset();
        err_en           = 1'b1;
        err_addr         = 32'h8;
        imem_req_ready_i = 1'b1;
        inst_ready_i     = 1'b1;
        repeat (8) tick();
        ncheck++;
        if (got_pc.size() < 4) begin
            nerr++; $display("FAIL err_len got %0d exp >=4", got_pc.size());
        end else begin
            ncheck++; if (got_err[1] !== 1'b0) begin nerr++; $display("FAIL err_before got %h exp 0", got_err[1]); end
            ncheck++; if (got_pc[2] !== 32'h8) begin nerr++; $display("FAIL err_pc got %h exp 8", got_pc[2]); end
            ncheck++; if (got_err[2] !== 1'b1) begin nerr++; $display("FAIL err_flag got %h exp 1", got_err[2]); end
            ncheck++; if (got_pc[3] !== 32'hC) begin nerr++; $display("FAIL err_next_pc got %h exp c", got_pc[3]); end
            ncheck++; if (got_err[3] !== 1'b0) begin nerr++; $display("FAIL err_next_flag got %h exp 0", got_err[3]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_req_ready_i = 1'b1;
        inst_ready_i     = 1'b0;
        repeat (4) tick();
        ncheck++; if (fq_count_o !== 3'd3) begin nerr++; $display("FAIL mid_count got %0d exp 3", fq_count_o); end
        ncheck++; if (inst_valid_o !== 1'b1) begin nerr++; $display("FAIL mid_valid got %h exp 1", inst_valid_o); end
        rst_n = 1'b0;
        idle_inputs();
        imem_req_ready_i = 1'b1;
        tick();
        ncheck++; if (inst_valid_o !== 1'b0) begin nerr++; $display("FAIL midrst_valid got %h exp 0", inst_valid_o); end
        ncheck++; if (fq_count_o !== 3'd0) begin nerr++; $display("FAIL midrst_count got %0d exp 0", fq_count_o); end
        ncheck++; if (imem_req_valid_o !== 1'b0) begin nerr++; $display("FAIL midrst_req_valid got %h exp 0", imem_req_valid_o); end
        req_log.delete();
        rst_n = 1'b1;
        tick();
        ncheck++;
        if (req_log.size() !== 1) begin
            nerr++; $display("FAIL midrst_req_count got %0d exp 1", req_log.size());
        end else if (req_log[0] !== 32'h0) begin
            nerr++; $display("FAIL midrst_first_req got %h exp 0", req_log[0]);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_same_cycle();
        test_error();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
        $finish;
    end

endmodule
